// File: rtl/multi_ch_fifo_bank.sv
// multi_ch_fifo_bank: NCH independent show-ahead synchronous FIFOs on mem_clk.
// Adds per-channel occupancy, almost-full/empty flags, sticky errors, flush.
//
// Ports:
//   mem_clk      clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset (pointers, counts, errors)
//   w_en/wdata   per-channel push request and data (channel i at i*DSIZE)
//   r_en         per-channel pop request
//   flush        per-channel synchronous empty, overrides w_en/r_en
//   err_clr      clears every sticky error flag
//   rdata        per-channel head entry, 0 while the channel is empty
//   full/empty   count == depth / count == 0
//   almost_*     count >= AF_TH / count <= AE_TH
//   count        per-channel occupancy (channel i at i*(ASIZE+1))
//   overflow     sticky: push seen while full
//   underflow    sticky: pop seen while empty
module multi_ch_fifo_bank #(
   parameter int NCH   = 4,
   parameter int DSIZE = 8,
   parameter int ASIZE = 4,
   parameter int AF_TH = 12,
   parameter int AE_TH = 2
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic [NCH-1:0]           w_en,
   input  logic [NCH*DSIZE-1:0]     wdata,
   input  logic [NCH-1:0]           r_en,
   input  logic [NCH-1:0]           flush,
   input  logic                     err_clr,
   output logic [NCH*DSIZE-1:0]     rdata,
   output logic [NCH-1:0]           full,
   output logic [NCH-1:0]           empty,
   output logic [NCH-1:0]           almost_full,
   output logic [NCH-1:0]           almost_empty,
   output logic [NCH*(ASIZE+1)-1:0] count,
   output logic [NCH-1:0]           overflow,
   output logic [NCH-1:0]           underflow
);

   localparam int DEPTH = 2**ASIZE;
   localparam int CW    = ASIZE + 1;

   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_TH);

   logic [NCH-1:0] ovf_q, ovf_d;
   logic [NCH-1:0] unf_q, unf_d;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DSIZE-1:0] mem_q [DEPTH];
      logic [ASIZE-1:0] wptr_q, wptr_d;
      logic [ASIZE-1:0] rptr_q, rptr_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             full_c, empty_c;
      logic             wr_acc, rd_acc;

      // Acceptance is judged on the registered count only, so a push
      // into a full channel is dropped even if a pop frees a slot.
      always_comb begin
         full_c  = (cnt_q == FULL_C);
         empty_c = (cnt_q == '0);
         wr_acc  = w_en[i] & ~full_c & ~flush[i];
         rd_acc  = r_en[i] & ~empty_c & ~flush[i];
         wptr_d  = wptr_q;
         rptr_d  = rptr_q;
         cnt_d   = cnt_q;
         if (flush[i]) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
         end else begin
            if (wr_acc) wptr_d = wptr_q + ASIZE'(1);
            if (rd_acc) rptr_d = rptr_q + ASIZE'(1);
            if (wr_acc & ~rd_acc) begin
               cnt_d = cnt_q + CW'(1);
            end else if (rd_acc & ~wr_acc) begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      end

      always_ff @(posedge mem_clk or negedge rst_n) begin
         if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
         end
      end

      // Storage is deliberately left out of reset.
      always_ff @(posedge mem_clk) begin
         if (wr_acc) mem_q[wptr_q] <= wdata[i*DSIZE +: DSIZE];
      end

      assign full[i]         = full_c;
      assign empty[i]        = empty_c;
      assign almost_full[i]  = (cnt_q >= AF_C);
      assign almost_empty[i] = (cnt_q <= AE_C);
      assign count[i*CW +: CW] = cnt_q;
      assign rdata[i*DSIZE +: DSIZE] =
         empty_c ? '0 : mem_q[rptr_q];
   end

   // A new error in the same cycle as err_clr must survive the clear.
   always_comb begin
      ovf_d = (ovf_q & ~{NCH{err_clr}}) | (w_en & full & ~flush);
      unf_d = (unf_q & ~{NCH{err_clr}}) | (r_en & empty & ~flush);
   end

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_multi_ch_fifo_bank.sv
// tb_multi_ch_fifo_bank: directed table plus hand sequences for
// multi_ch_fifo_bank with default parameters (4 ch, 8b, depth 16).
module tb_multi_ch_fifo_bank;

   logic        mem_clk;
   logic        rst_n;
   logic [3:0]  w_en;
   logic [31:0] wdata;
   logic [3:0]  r_en;
   logic [3:0]  flush;
   logic        err_clr;
   logic [31:0] rdata;
   logic [3:0]  full;
   logic [3:0]  empty;
   logic [3:0]  almost_full;
   logic [3:0]  almost_empty;
   logic [19:0] count;
   logic [3:0]  overflow;
   logic [3:0]  underflow;

   int checks   = 0;
   int failures = 0;

   multi_ch_fifo_bank dut (
      .mem_clk      (mem_clk),
      .rst_n        (rst_n),
      .w_en         (w_en),
      .wdata        (wdata),
      .r_en         (r_en),
      .flush        (flush),
      .err_clr      (err_clr),
      .rdata        (rdata),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   typedef struct {
      logic [3:0]  w_en;
      logic [31:0] wdata;
      logic [3:0]  r_en;
      logic [3:0]  flush;
      logic        err_clr;
      int          ch;
      logic [4:0]  cnt;
      logic [7:0]  rd;
      logic [5:0]  flags;  // full, empty, af, ae, ovf, unf
   } vec_t;

   vec_t tbl [33];
   logic [7:0] q1 [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_ch(input string nm, input int ch,
                         input logic [4:0] ecnt, input logic [7:0] erd,
                         input logic [5:0] efl);
      logic [5:0] fl;
      fl = {full[ch], empty[ch], almost_full[ch], almost_empty[ch],
            overflow[ch], underflow[ch]};
      chk({nm, "_cnt"}, 32'(count[ch*5 +: 5]), 32'(ecnt));
      chk({nm, "_rd"}, 32'(rdata[ch*8 +: 8]), 32'(erd));
      chk({nm, "_flags"}, 32'(fl), 32'(efl));
   endtask

   task automatic step(input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re, input logic [3:0] fl,
                       input logic ec);
      @(negedge mem_clk);
      w_en    = we;
      wdata   = wd;
      r_en    = re;
      flush   = fl;
      err_clr = ec;
      @(posedge mem_clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_empty"}, 32'(empty), 32'hF);
      chk({nm, "_ae"}, 32'(almost_empty), 32'hF);
      chk({nm, "_full"}, 32'(full), 32'h0);
      chk({nm, "_af"}, 32'(almost_full), 32'h0);
      chk({nm, "_ovf"}, 32'(overflow), 32'h0);
      chk({nm, "_unf"}, 32'(underflow), 32'h0);
      chk({nm, "_count"}, 32'(count), 32'h0);
      chk({nm, "_rdata"}, rdata, 32'h0);
   endtask

   initial begin
      rst_n   = 1'b0;
      w_en    = '0;
      wdata   = '0;
      r_en    = '0;
      flush   = '0;
      err_clr = 1'b0;

      // Channel 0: 16 pushes, one overflow push, 16 pops.
      for (int k = 0; k < 16; k++) begin
         tbl[k] = '{w_en: 4'b0001, wdata: {24'h0, 8'(8'h11 + k)},
                    r_en: 4'b0, flush: 4'b0, err_clr: 1'b0, ch: 0,
                    cnt: 5'(k + 1), rd: 8'h11,
                    flags: {(k + 1) == 16, 1'b0, (k + 1) >= 12,
                            (k + 1) <= 2, 1'b0, 1'b0}};
      end
      tbl[16] = '{w_en: 4'b0001, wdata: 32'hAA, r_en: 4'b0,
                  flush: 4'b0, err_clr: 1'b0, ch: 0, cnt: 5'd16,
                  rd: 8'h11, flags: 6'b101010};
      for (int j = 1; j <= 16; j++) begin
         tbl[16 + j] = '{w_en: 4'b0, wdata: 32'h0, r_en: 4'b0001,
                         flush: 4'b0, err_clr: 1'b0, ch: 0,
                         cnt: 5'(16 - j),
                         rd: (j < 16) ? 8'(8'h11 + j) : 8'h00,
                         flags: {1'b0, j == 16, (16 - j) >= 12,
                                 (16 - j) <= 2, 1'b1, 1'b0}};
      end

      #3;
      chk_reset_vals("reset");
      @(negedge mem_clk);
      @(negedge mem_clk);
      rst_n = 1'b1;
      step(4'b0, 32'h0, 4'b0, 4'b0, 1'b0);
      chk_reset_vals("idle");

      for (int v = 0; v < 33; v++) begin
         step(tbl[v].w_en, tbl[v].wdata, tbl[v].r_en, tbl[v].flush,
              tbl[v].err_clr);
         chk_ch($sformatf("tbl%0d", v), tbl[v].ch, tbl[v].cnt,
                tbl[v].rd, tbl[v].flags);
         chk($sformatf("tbl%0d_others", v), 32'(count[19:5]), 32'h0);
      end

      // Channel 1: 5 deep, then push+pop across the pointer wrap.
      for (int i = 0; i < 5; i++) begin
         step(4'b0010, {16'h0, 8'(8'h50 + i), 8'h0}, 4'b0, 4'b0, 1'b0);
         q1.push_back(8'(8'h50 + i));
      end
      chk_ch("ch1_fill", 1, 5'd5, 8'h50, 6'b000000);
      for (int i = 0; i < 14; i++) begin
         step(4'b0010, {16'h0, 8'(8'h60 + i), 8'h0}, 4'b0010, 4'b0,
              1'b0);
         q1.push_back(8'(8'h60 + i));
         void'(q1.pop_front());
         chk($sformatf("ch1_pp%0d_cnt", i), 32'(count[9:5]), 32'd5);
         chk($sformatf("ch1_pp%0d_rd", i), 32'(rdata[15:8]),
             32'(q1[0]));
      end

      // Channel 2 empty: push accepted, pop dropped as underflow.
      step(4'b0100, 32'h0077_0000, 4'b0100, 4'b0, 1'b0);
      chk_ch("ch2_wr_rd_empty", 2, 5'd1, 8'h77, 6'b000101);

      // Channel 3: 7 deep, then flush with push/pop; ch0 flushed too.
      for (int i = 0; i < 7; i++) begin
         step(4'b1000, {8'(8'h30 + i), 24'h0}, 4'b0, 4'b0, 1'b0);
      end
      chk_ch("ch3_fill", 3, 5'd7, 8'h30, 6'b000000);
      step(4'b1001, 32'h3900_0099, 4'b1001, 4'b1001, 1'b0);
      chk_ch("ch3_flush", 3, 5'd0, 8'h00, 6'b010100);
      chk_ch("ch0_flush", 0, 5'd0, 8'h00, 6'b010110);
      chk("flush_keeps_unf2", 32'(underflow), 32'b0100);

      step(4'b0, 32'h0, 4'b0, 4'b0, 1'b1);
      chk("clr_ovf", 32'(overflow), 32'h0);
      chk("clr_unf", 32'(underflow), 32'h0);

      step(4'b0, 32'h0, 4'b1000, 4'b0, 1'b0);
      chk("unf3_set", 32'(underflow), 32'b1000);

      for (int i = 0; i < 16; i++) begin
         step(4'b0001, {24'h0, 8'(8'h80 + i)}, 4'b0, 4'b0, 1'b0);
      end
      chk_ch("ch0_refill", 0, 5'd16, 8'h80, 6'b101000);
      step(4'b0001, 32'hEE, 4'b0, 4'b0, 1'b1);
      chk("clr_vs_set_ovf", 32'(overflow), 32'b0001);
      chk("clr_vs_set_unf", 32'(underflow), 32'b0000);
      chk_ch("ch0_after_clr", 0, 5'd16, 8'h80, 6'b101010);

      // Asynchronous reset mid-burst, between clock edges.
      step(4'b1111, 32'hA1B2_C3D4, 4'b0, 4'b0, 1'b0);
      @(posedge mem_clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(negedge mem_clk);
      w_en  = '0;
      rst_n = 1'b1;
      step(4'b0001, 32'hC3, 4'b0, 4'b0, 1'b0);
      chk_ch("post_rst_wr1", 0, 5'd1, 8'hC3, 6'b000100);
      step(4'b0001, 32'hC4, 4'b0, 4'b0, 1'b0);
      step(4'b0, 32'h0, 4'b0001, 4'b0, 1'b0);
      chk_ch("post_rst_rd", 0, 5'd1, 8'hC4, 6'b000100);
      chk("post_rst_others", 32'(count[19:5]), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
